seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_pattern_detector.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial bit-pattern detector with a loadable
// target, overlap mode and a saturating match counter.
//
// Ports:
//   clock       in   rising-edge clock
//   nreset      in   async active-low reset
//   pat_load    in   latch pat_in as new target
//   pat_in      in   [N-1:0] target; [N-1] first bit in time
//   overlap     in   1 = overlapping, 0 = restart after match
//   en          in   qualifies inp this cycle
//   inp         in   serial data bit
//   clr_count   in   sync clear of match_count (wins over match)
//   match       out  Mealy match flag, same cycle as last bit
//   match_count out  [CNT_W-1:0] saturating match count
module seq_pattern_detector #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             overlap,
  input  logic             en,
  input  logic             inp,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(N);

  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);
  localparam logic [FW-1:0] FILL_PRE = FW'(N - 2);

  typedef logic [N-2:0] hist_t;

  typedef enum logic [1:0] {
    UNLOADED = 2'b00,
    FILL     = 2'b01,
    RUN      = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     pat_q;
  logic [N-1:0]     pat_d;
  hist_t            hist_q;
  hist_t            hist_d;
  hist_t            hist_sh;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_sat;
  logic             hit;

  // hist[0] is the newest bit; truncation drops the oldest.
  assign hist_sh = hist_t'({hist_q, inp});

  assign hit = (inp == pat_q[0])
             & (hist_q == pat_q[N-1:1]);

  assign match = (state_q == RUN)
               & en
               & ~pat_load
               & hit;

  assign cnt_sat     = &cnt_q;
  assign match_count = cnt_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (pat_load) begin
      // The bit presented with pat_load is dropped.
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else begin
      unique case (state_q)
        UNLOADED: begin
          state_d = UNLOADED;
        end
        FILL: begin
          if (en) begin
            hist_d = hist_sh;
            if (fill_q >= FILL_PRE) begin
              fill_d  = FILL_MAX;
              state_d = RUN;
            end else begin
              fill_d = fill_q + FW'(1);
            end
          end
        end
        RUN: begin
          fill_d = FILL_MAX;
          if (en) begin
            if (match && !overlap) begin
              // Restart: the matching bit is not reused.
              hist_d  = '0;
              fill_d  = '0;
              state_d = FILL;
            end else begin
              hist_d = hist_sh;
            end
          end
        end
        default: begin
          // Unused encoding recovers to UNLOADED.
          hist_d  = '0;
          fill_d  = '0;
          state_d = UNLOADED;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    priority case (1'b1)
      clr_count:          cnt_d = '0;
      (match & ~cnt_sat): cnt_d = cnt_q + CNT_W'(1);
      default:            cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= UNLOADED;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed bench for seq_pattern_detector.
// dut_a uses N=3/CNT_W=8, dut_b uses N=3/CNT_W=2 for saturation.
module tb_seq_pattern_detector;

  logic       clock;
  logic       nreset;

  logic       a_ld;
  logic [2:0] a_pat;
  logic       a_ov;
  logic       a_en;
  logic       a_inp;
  logic       a_clr;
  logic       a_m;
  logic [7:0] a_cnt;

  logic       b_ld;
  logic [2:0] b_pat;
  logic       b_ov;
  logic       b_en;
  logic       b_inp;
  logic       b_clr;
  logic       b_m;
  logic [1:0] b_cnt;

  int passed = 0;
  int total  = 0;

  bit s31 [8] = '{1, 0, 1, 0, 1, 1, 0, 1};
  bit m31 [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
  logic [1:0] exp_b [7] = '{0, 0, 1, 2, 3, 3, 3};

  seq_pattern_detector #(.N(3), .CNT_W(8)) dut_a (
    .clock      (clock),
    .nreset     (nreset),
    .pat_load   (a_ld),
    .pat_in     (a_pat),
    .overlap    (a_ov),
    .en         (a_en),
    .inp        (a_inp),
    .clr_count  (a_clr),
    .match      (a_m),
    .match_count(a_cnt)
  );

  seq_pattern_detector #(.N(3), .CNT_W(2)) dut_b (
    .clock      (clock),
    .nreset     (nreset),
    .pat_load   (b_ld),
    .pat_in     (b_pat),
    .overlap    (b_ov),
    .en         (b_en),
    .inp        (b_inp),
    .clr_count  (b_clr),
    .match      (b_m),
    .match_count(b_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Inputs change just after negedge; match sampled 1 ns later.
  task automatic a_step(input logic ld, input logic [2:0] p,
                        input logic e, input logic b,
                        input logic clr, input logic exp_m,
                        input string tag);
    a_ld  = ld;
    a_pat = p;
    a_en  = e;
    a_inp = b;
    a_clr = clr;
    #1;
    chk(tag, a_m, exp_m);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic b_step(input logic ld, input logic [2:0] p,
                        input logic e, input logic b,
                        input logic clr, input logic exp_m,
                        input string tag);
    b_ld  = ld;
    b_pat = p;
    b_en  = e;
    b_inp = b;
    b_clr = clr;
    #1;
    chk(tag, b_m, exp_m);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    nreset = 1'b0;
    a_ld = 0; a_pat = 3'b000; a_ov = 1; a_clr = 0;
    a_en = 1; a_inp = 1;
    b_ld = 0; b_pat = 3'b000; b_ov = 1; b_clr = 0;
    b_en = 0; b_inp = 0;

    @(negedge clock);
    chk("rst_match", a_m, 1'b0);
    chk("rst_cnt_a", a_cnt, 8'd0);
    chk("rst_cnt_b", b_cnt, 2'd0);
    @(negedge clock);
    nreset = 1'b1;

    // UNLOADED ignores the stream
    a_step(0, 3'b000, 1, 1, 0, 0, "unl_b1");
    a_step(0, 3'b000, 1, 0, 0, 0, "unl_b2");
    a_step(0, 3'b000, 1, 0, 0, 0, "unl_b3");
    chk("unl_cnt", a_cnt, 8'd0);

    // overlapping 101 on 1,0,1,0,1
    a_ov = 1;
    a_step(1, 3'b101, 1, 1, 0, 0, "ov_load");
    a_step(0, 3'b101, 1, 1, 0, 0, "ov_b1");
    a_step(0, 3'b101, 1, 0, 0, 0, "ov_b2");
    a_step(0, 3'b101, 1, 1, 0, 1, "ov_b3");
    a_step(0, 3'b101, 1, 0, 0, 0, "ov_b4");
    a_step(0, 3'b101, 1, 1, 0, 1, "ov_b5");
    chk("ov_cnt", a_cnt, 8'd2);

    // reload keeps count, clear zeroes it
    a_step(1, 3'b101, 1, 1, 0, 0, "reload_m");
    chk("reload_cnt", a_cnt, 8'd2);
    a_step(0, 3'b101, 0, 1, 1, 0, "clr_m");
    chk("clr_cnt", a_cnt, 8'd0);

    // non-overlapping 101 on 1,0,1,0,1,1,0,1
    a_ov = 0;
    for (int i = 0; i < 8; i++) begin
      a_step(0, 3'b101, 1, s31[i], 0, m31[i],
             $sformatf("nov_b%0d", i + 1));
    end
    chk("nov_cnt", a_cnt, 8'd2);

    // en gaps: 1,_,_,0,_,_,1 with inp=1 in gaps
    a_ov = 1;
    a_step(1, 3'b101, 0, 0, 1, 0, "gap_load");
    chk("gap_clr", a_cnt, 8'd0);
    a_step(0, 3'b101, 1, 1, 0, 0, "gap_v1");
    a_step(0, 3'b101, 0, 1, 0, 0, "gap_g1");
    a_step(0, 3'b101, 0, 1, 0, 0, "gap_g2");
    a_step(0, 3'b101, 1, 0, 0, 0, "gap_v2");
    a_step(0, 3'b101, 0, 1, 0, 0, "gap_g3");
    a_step(0, 3'b101, 0, 1, 0, 0, "gap_g4");
    a_step(0, 3'b101, 1, 1, 0, 1, "gap_v3");
    chk("gap_cnt", a_cnt, 8'd1);

    // reload 011 mid-stream: load cycle bit dropped
    a_step(1, 3'b101, 1, 1, 0, 0, "rl_load1");
    a_step(0, 3'b101, 1, 1, 0, 0, "rl_b1");
    a_step(0, 3'b101, 1, 0, 0, 0, "rl_b2");
    a_step(1, 3'b011, 1, 1, 0, 0, "rl_load2");
    a_step(0, 3'b011, 1, 0, 0, 0, "rl_c1");
    a_step(0, 3'b011, 1, 1, 0, 0, "rl_c2");
    a_step(0, 3'b011, 1, 1, 0, 1, "rl_c3");
    chk("rl_cnt", a_cnt, 8'd2);
    a_en = 0;

    // CNT_W=2 saturation with 111 on a run of ones
    b_step(1, 3'b111, 1, 1, 0, 0, "sat_load");
    for (int i = 0; i < 7; i++) begin
      b_step(0, 3'b111, 1, 1, 0, (i >= 2),
             $sformatf("sat_m%0d", i + 1));
      chk($sformatf("sat_cnt%0d", i + 1), b_cnt, exp_b[i]);
    end
    b_step(0, 3'b111, 1, 1, 1, 1, "sat_clr_m");
    chk("sat_clr_cnt", b_cnt, 2'd0);
    b_en = 0;

    // mid-stream async reset discards pattern
    a_step(1, 3'b101, 1, 1, 0, 0, "ar_load");
    a_step(0, 3'b101, 1, 1, 0, 0, "ar_b1");
    a_step(0, 3'b101, 1, 0, 0, 0, "ar_b2");
    chk("ar_cnt_pre", a_cnt, 8'd2);
    a_en  = 1;
    a_inp = 1;
    nreset = 1'b0;
    #1;
    chk("ar_async_cnt", a_cnt, 8'd0);
    chk("ar_async_m", a_m, 1'b0);
    #2 nreset = 1'b1;
    #1;
    chk("ar_rel_m", a_m, 1'b0);
    @(posedge clock);
    @(negedge clock);
    a_step(0, 3'b101, 1, 1, 0, 0, "ar_p1");
    a_step(0, 3'b101, 1, 0, 0, 0, "ar_p2");
    a_step(0, 3'b101, 1, 1, 0, 0, "ar_p3");
    chk("ar_cnt_post", a_cnt, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
